// File: rtl/imem_fetch_sequencer.sv
// Instruction fetch sequencer: holds IMemAddr for RD_CYCLES cycles, captures the
// returned word into an in-order queue drained by decode, supports redirects and halts at PC_LIMIT.
//
// state | meaning
// ------+-----------------------------------------------------------
// INIT  | first edge after reset release, loads StartPC
// FETCH | address held, counting read cycles
// STALL | read complete but queue full; address held until space
// HALT  | fetch reached PC_LIMIT; queue still drains
module imem_fetch_sequencer #(
    parameter int          RD_CYCLES = 2,
    parameter int          DEPTH     = 2,
    parameter logic [63:0] PC_LIMIT  = 64'h58
) (
    input  logic        CLK,
    input  logic        Reset_L,
    input  logic [63:0] StartPC,
    output logic [63:0] IMemAddr,
    input  logic [31:0] IMemData,
    output logic        InstValid,
    input  logic        InstReady,
    output logic [31:0] InstData,
    output logic [63:0] InstPC,
    input  logic        Redirect,
    input  logic [63:0] RedirectPC,
    output logic        Halted
);

    localparam int WC_W  = (RD_CYCLES > 1) ? $clog2(RD_CYCLES) : 1;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [WC_W-1:0]  WC_LAST  = WC_W'(RD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_FETCH = 2'd1,
        S_STALL = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [63:0]       fetch_pc, fetch_pc_nxt;
    logic [WC_W-1:0]   wait_cnt, wait_cnt_nxt;

    logic [31:0]       q_data [DEPTH];
    logic [63:0]       q_pc   [DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count;

    logic [63:0] start_pc_al, redir_pc_al, pc_inc;
    logic        pop, space, capture, redirect_act;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign start_pc_al  = StartPC & ~64'h3;
    assign redir_pc_al  = RedirectPC & ~64'h3;
    assign pc_inc       = fetch_pc + 64'd4;
    assign pop          = (count != '0) && InstReady;
    assign space        = (count != CNT_FULL) || pop;
    assign redirect_act = Redirect && (state != S_INIT);
    assign capture      = ((state == S_FETCH) || (state == S_STALL)) &&
                          (wait_cnt == WC_LAST) && space;

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state    <= S_INIT;
            fetch_pc <= '0;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Entering HALT parks the address at PC_LIMIT regardless of how HALT was reached.
    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        wait_cnt_nxt = wait_cnt;
        case (state)
            S_INIT: begin
                wait_cnt_nxt = '0;
                if (start_pc_al >= PC_LIMIT) begin
                    state_nxt    = S_HALT;
                    fetch_pc_nxt = PC_LIMIT;
                end else begin
                    state_nxt    = S_FETCH;
                    fetch_pc_nxt = start_pc_al;
                end
            end
            S_FETCH, S_STALL: begin
                if (wait_cnt != WC_LAST) begin
                    wait_cnt_nxt = wait_cnt + WC_W'(1);
                end else if (space) begin
                    wait_cnt_nxt = '0;
                    if (pc_inc >= PC_LIMIT) begin
                        state_nxt    = S_HALT;
                        fetch_pc_nxt = PC_LIMIT;
                    end else begin
                        state_nxt    = S_FETCH;
                        fetch_pc_nxt = pc_inc;
                    end
                end else begin
                    state_nxt = S_STALL;
                end
            end
            S_HALT: state_nxt = S_HALT;
            default: state_nxt = S_INIT;
        endcase
        if (redirect_act) begin
            wait_cnt_nxt = '0;
            if (redir_pc_al >= PC_LIMIT) begin
                state_nxt    = S_HALT;
                fetch_pc_nxt = PC_LIMIT;
            end else begin
                state_nxt    = S_FETCH;
                fetch_pc_nxt = redir_pc_al;
            end
        end
    end

    always_comb begin
        IMemAddr  = fetch_pc;
        Halted    = (state == S_HALT);
        InstValid = (count != '0);
        InstData  = q_data[rd_ptr];
        InstPC    = q_pc[rd_ptr];
    end

    // A redirect discards both the capture and the pop of its cycle.
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_data[i] <= '0;
                q_pc[i]   <= '0;
            end
        end else if (redirect_act) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (capture) begin
                q_data[wr_ptr] <= IMemData;
                q_pc[wr_ptr]   <= fetch_pc;
                wr_ptr         <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (capture && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !capture) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Self-checking bench for imem_fetch_sequencer: directed scenarios followed by a
// randomized phase scored against a program-order model of the delivered stream.
module tb_imem_fetch_sequencer;

    localparam logic [63:0] LIMIT = 64'h58;

    logic        CLK = 1'b0;
    logic        Reset_L = 1'b0;
    logic [63:0] StartPC = '0;
    logic [63:0] IMemAddr;
    logic [31:0] IMemData;
    logic        InstValid;
    logic        InstReady = 1'b0;
    logic [31:0] InstData;
    logic [63:0] InstPC;
    logic        Redirect = 1'b0;
    logic [63:0] RedirectPC = '0;
    logic        Halted;

    int n_assert = 0;
    int n_fail   = 0;

    imem_fetch_sequencer #(.RD_CYCLES(2), .DEPTH(2), .PC_LIMIT(LIMIT)) dut (
        .CLK(CLK), .Reset_L(Reset_L), .StartPC(StartPC), .IMemAddr(IMemAddr),
        .IMemData(IMemData), .InstValid(InstValid), .InstReady(InstReady),
        .InstData(InstData), .InstPC(InstPC), .Redirect(Redirect),
        .RedirectPC(RedirectPC), .Halted(Halted)
    );

    always #5 CLK = ~CLK;

    // Test program; unnamed slots hold filler words tagged with their index.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        int idx;
        if (a >= LIMIT) return 32'hDEAD0000 | {16'h0, a[15:0]};
        idx = int'(a[6:2]);
        case (idx)
            0:       return 32'hF84003E9;
            1:       return 32'hF84083EA;
            2:       return 32'hF84103EB;
            10:      return 32'h17FFFFFD;
            21:      return 32'hF84283EA;
            default: return 32'hA5000000 | 32'(idx);
        endcase
    endfunction

    assign IMemData = mem_word(IMemAddr);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic do_reset(input logic [63:0] start);
        @(negedge CLK);
        Reset_L  = 1'b0;
        Redirect = 1'b0;
        StartPC  = start;
        repeat (2) tick();
        Reset_L = 1'b1;
    endtask

    task automatic wait_valid(input int max_cycles);
        for (int i = 0; i < max_cycles && !InstValid; i++) tick();
        chk("wait_valid_timeout", InstValid, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] exp_pc, last_pc, rpc;
        logic [31:0] last_data;
        logic        any_valid, redir_n, ready_n, prev_redir, prev_halt;
        int          delivered;

        // Reset values
        @(negedge CLK);
        chk("rst_addr", IMemAddr, 64'h0);
        chk("rst_valid", InstValid, 1'b0);
        chk("rst_data", InstData, 32'h0);
        chk("rst_pc", InstPC, 64'h0);
        chk("rst_halted", Halted, 1'b0);

        // First fetch latency and throughput
        InstReady = 1'b1;
        do_reset(64'h0);
        tick();
        chk("lat_e1_valid", InstValid, 1'b0);
        tick();
        chk("lat_e2_valid", InstValid, 1'b0);
        tick();
        chk("lat_e3_valid", InstValid, 1'b1);
        chk("lat_e3_pc", InstPC, 64'h0);
        chk("lat_e3_data", InstData, 32'hF84003E9);
        tick();
        chk("lat_e4_valid", InstValid, 1'b0);
        tick();
        chk("lat_e5_pc", InstPC, 64'h4);
        chk("lat_e5_data", InstData, 32'hF84083EA);

        // Backpressure fills the queue, then drains with simultaneous push/pop
        InstReady = 1'b0;
        do_reset(64'h0);
        repeat (7) tick();
        chk("stall_addr", IMemAddr, 64'h8);
        chk("stall_head_pc", InstPC, 64'h0);
        repeat (2) tick();
        chk("stall_addr_hold", IMemAddr, 64'h8);
        chk("stall_head_pc_hold", InstPC, 64'h0);
        chk("stall_head_data_hold", InstData, 32'hF84003E9);
        InstReady = 1'b1;
        tick();
        chk("drain1_valid", InstValid, 1'b1);
        chk("drain1_pc", InstPC, 64'h4);
        tick();
        chk("drain2_valid", InstValid, 1'b1);
        chk("drain2_pc", InstPC, 64'h8);
        chk("drain2_data", InstData, 32'hF84103EB);
        tick();
        chk("drain3_pc", InstPC, 64'hC);

        // Redirect on a full queue with pop and capture both due
        InstReady = 1'b0;
        do_reset(64'h0);
        repeat (7) tick();
        InstReady  = 1'b1;
        Redirect   = 1'b1;
        RedirectPC = 64'h2A;
        tick();
        Redirect = 1'b0;
        chk("redir_valid", InstValid, 1'b0);
        chk("redir_addr", IMemAddr, 64'h28);
        wait_valid(10);
        chk("redir_pc", InstPC, 64'h28);
        chk("redir_data", InstData, 32'h17FFFFFD);

        // Run to the end of the program
        InstReady = 1'b1;
        do_reset(64'h0);
        last_pc = '1;
        last_data = '0;
        for (int i = 0; i < 200 && !(Halted && !InstValid); i++) begin
            tick();
            if (InstValid) begin
                last_pc   = InstPC;
                last_data = InstData;
            end
        end
        chk("halt_last_pc", last_pc, 64'h54);
        chk("halt_last_data", last_data, 32'hF84283EA);
        chk("halt_flag", Halted, 1'b1);
        chk("halt_addr", IMemAddr, 64'h58);
        any_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (InstValid) any_valid = 1'b1;
        end
        chk("halt_no_valid", any_valid, 1'b0);
        Redirect   = 1'b1;
        RedirectPC = 64'h0;
        tick();
        Redirect = 1'b0;
        chk("unhalt_flag", Halted, 1'b0);
        wait_valid(10);
        chk("unhalt_pc", InstPC, 64'h0);
        chk("unhalt_data", InstData, 32'hF84003E9);

        // Asynchronous reset while stalled
        InstReady = 1'b0;
        do_reset(64'h0);
        repeat (7) tick();
        #2 Reset_L = 1'b0;
        #1;
        chk("areset_addr", IMemAddr, 64'h0);
        chk("areset_valid", InstValid, 1'b0);
        chk("areset_data", InstData, 32'h0);
        chk("areset_pc", InstPC, 64'h0);
        chk("areset_halted", Halted, 1'b0);
        StartPC   = 64'h10;
        InstReady = 1'b1;
        @(negedge CLK);
        Reset_L = 1'b1;
        repeat (3) tick();
        chk("areset_restart_valid", InstValid, 1'b1);
        chk("areset_restart_pc", InstPC, 64'h10);
        chk("areset_restart_data", InstData, mem_word(64'h10));

        // Randomized handshake and redirects against the program-order model
        exp_pc = {$urandom_range(0, 21), 2'b00};
        InstReady = 1'b0;
        do_reset(exp_pc);
        prev_redir = 1'b0;
        prev_halt  = 1'b0;
        delivered  = 0;
        for (int i = 0; i < 800; i++) begin
            if (InstValid) begin
                chk("rand_pc", InstPC, exp_pc);
                chk("rand_data", InstData, mem_word(exp_pc));
            end
            if (prev_redir) begin
                chk("rand_redir_flush", InstValid, 1'b0);
                chk("rand_redir_halted", Halted, prev_halt);
            end
            ready_n = ($urandom_range(0, 2) != 0);
            redir_n = (i != 0) && ($urandom_range(0, 29) == 0);
            rpc     = 64'($urandom_range(0, 'h60));
            InstReady  = ready_n;
            Redirect   = redir_n;
            RedirectPC = rpc;
            if (redir_n) begin
                exp_pc    = rpc & ~64'h3;
                prev_halt = (exp_pc >= LIMIT);
            end else if (InstValid && ready_n) begin
                exp_pc = exp_pc + 64'd4;
                delivered++;
            end
            prev_redir = redir_n;
            tick();
        end
        Redirect = 1'b0;
        chk("rand_progress", delivered > 50, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
